// File: rtl/bp_be_loop_prefetch_scheduler_pkg.sv
// Shared types for the loop prefetch scheduler and its stream slots.
package bp_be_loop_prefetch_scheduler_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg
  } bp_params_e;

  typedef enum logic [0:0] {
    e_lpf_idle,
    e_lpf_run
  } bp_be_lpf_state_e;

  // Virtual address width implied by a processor configuration
  function automatic int bp_vaddr_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 39;
      default:          return 39;
    endcase
  endfunction

endpackage

// File: rtl/bp_be_loop_prefetch_scheduler_slot.sv
// One striding stream: address generator, trip/lookahead accounting, retire tracking.
module bp_be_loop_prefetch_slot
  import bp_be_loop_prefetch_scheduler_pkg::*;
  #(parameter int vaddr_width_p  = 39
  , parameter int output_range_p = 8
  , parameter int stride_width_p = 8
  , parameter int lookahead_p    = 4
  )
  (input  logic                      clk
  , input  logic                      reset
  , input  logic                      flush
  , input  logic                      load
  , input  logic [vaddr_width_p-1:0]  load_pc
  , input  logic [vaddr_width_p-1:0]  load_addr
  , input  logic [stride_width_p-1:0] load_stride
  , input  logic [output_range_p-1:0] load_iters
  , input  logic                      issue
  , input  logic                      retire_v
  , input  logic [vaddr_width_p-1:0]  retire_pc
  , output logic                      run
  , output logic [vaddr_width_p-1:0]  pc
  , output logic [vaddr_width_p-1:0]  next_addr
  , output logic                      eligible
  );

  localparam int infl_w = $clog2(lookahead_p + 1);

  bp_be_lpf_state_e            state;
  logic [stride_width_p-1:0]   stride_r;
  logic [output_range_p-1:0]   iters_r, issued_r;
  logic [infl_w-1:0]           inflight_r;
  logic [vaddr_width_p-1:0]    load_step, step;
  logic                        retire, done;

  assign load_step = {{(vaddr_width_p-stride_width_p){load_stride[stride_width_p-1]}}, load_stride};
  assign step      = {{(vaddr_width_p-stride_width_p){stride_r[stride_width_p-1]}}, stride_r};

  assign run      = (state == e_lpf_run);
  assign retire   = run & retire_v & (retire_pc == pc);
  assign done     = (issued_r == iters_r);
  assign eligible = run & ~done & (inflight_r < infl_w'(lookahead_p));

  // Stream state: load/refresh overrides any same-cycle issue or retire
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= e_lpf_idle;
      pc         <= '0;
      next_addr  <= '0;
      stride_r   <= '0;
      iters_r    <= '0;
      issued_r   <= '0;
      inflight_r <= '0;
    end else if (flush) begin
      state <= e_lpf_idle;
    end else if (load) begin
      pc         <= load_pc;
      next_addr  <= load_addr + load_step;
      stride_r   <= load_stride;
      iters_r    <= load_iters;
      issued_r   <= '0;
      inflight_r <= '0;
      state      <= (load_iters != '0) ? e_lpf_run : e_lpf_idle;
    end else if (run) begin
      if (done) begin
        state <= e_lpf_idle;
      end else begin
        if (issue) begin
          next_addr <= next_addr + step;
          issued_r  <= issued_r + output_range_p'(1);
        end
        if (issue & ~retire)
          inflight_r <= inflight_r + infl_w'(1);
        else if (~issue & retire & (inflight_r != '0))
          inflight_r <= inflight_r - infl_w'(1);
      end
    end
  end

endmodule

// File: rtl/bp_be_loop_prefetch_scheduler.sv
// Loop prefetch scheduler: allocates stream slots from inference results and
// issues one prefetch per cycle round-robin through a one-entry output buffer.
module bp_be_loop_prefetch_scheduler
  import bp_be_loop_prefetch_scheduler_pkg::*;
  #(parameter bp_params_e bp_params_p = e_bp_default_cfg
  , parameter int output_range_p = 8
  , parameter int stride_width_p = 8
  , parameter int entries_p      = 2
  , parameter int lookahead_p    = 4
  , localparam int vaddr_width_p = bp_vaddr_width(bp_params_p)
  )
  (input  logic                      clk_i
  , input  logic                      reset_i
  , input  logic                      loop_v_i
  , input  logic [output_range_p-1:0] loop_iters_i
  , input  logic [vaddr_width_p-1:0]  loop_pc_i
  , input  logic [vaddr_width_p-1:0]  loop_addr_i
  , input  logic [stride_width_p-1:0] loop_stride_i
  , output logic                      loop_yumi_o
  , input  logic                      commit_v_i
  , input  logic [vaddr_width_p-1:0]  commit_pc_i
  , input  logic                      flush_i
  , output logic [vaddr_width_p-1:0]  pf_vaddr_o
  , output logic                      pf_v_o
  , input  logic                      pf_ready_i
  , output logic                      busy_o
  );

  localparam int sel_w = (entries_p > 1) ? $clog2(entries_p) : 1;

  logic [entries_p-1:0]     run, eligible, load_sel, issue;
  logic [vaddr_width_p-1:0] slot_pc   [entries_p];
  logic [vaddr_width_p-1:0] slot_addr [entries_p];
  logic                     match_v, free_v, accept, found, grant_v, take;
  logic [sel_w-1:0]         match_idx, free_idx, load_idx, grant_idx, rr_last;
  logic                     buf_v;
  logic [vaddr_width_p-1:0] buf_addr;

  // Slot selection: a running slot with the same pc is refreshed, else lowest idle slot
  always_comb begin
    match_v   = 1'b0;
    match_idx = '0;
    free_v    = 1'b0;
    free_idx  = '0;
    load_sel  = '0;
    for (int unsigned i = 0; i < entries_p; i++) begin
      if (!match_v && run[i] && (slot_pc[i] == loop_pc_i)) begin
        match_v   = 1'b1;
        match_idx = sel_w'(i);
      end
      if (!free_v && !run[i]) begin
        free_v   = 1'b1;
        free_idx = sel_w'(i);
      end
    end
    accept   = loop_v_i & ~flush_i & ~reset_i & (match_v | free_v);
    load_idx = match_v ? match_idx : free_idx;
    for (int unsigned i = 0; i < entries_p; i++)
      load_sel[i] = accept & (load_idx == sel_w'(i));
  end

  // Round-robin grant: search slots above the last winner first, then wrap around
  always_comb begin
    take      = ~buf_v | pf_ready_i;
    found     = 1'b0;
    grant_idx = rr_last;
    issue     = '0;
    for (int unsigned i = 0; i < entries_p; i++) begin
      if (!found && eligible[i] && (sel_w'(i) > rr_last)) begin
        found     = 1'b1;
        grant_idx = sel_w'(i);
      end
    end
    for (int unsigned i = 0; i < entries_p; i++) begin
      if (!found && eligible[i] && (sel_w'(i) <= rr_last)) begin
        found     = 1'b1;
        grant_idx = sel_w'(i);
      end
    end
    grant_v = found & take & ~flush_i & ~reset_i;
    for (int unsigned i = 0; i < entries_p; i++)
      issue[i] = grant_v & (grant_idx == sel_w'(i));
  end

  for (genvar g = 0; g < entries_p; g++) begin : g_slot
    bp_be_loop_prefetch_slot
      #(.vaddr_width_p (vaddr_width_p)
      , .output_range_p(output_range_p)
      , .stride_width_p(stride_width_p)
      , .lookahead_p   (lookahead_p)
      )
      slot
      (.clk        (clk_i)
      , .reset      (reset_i)
      , .flush      (flush_i)
      , .load       (load_sel[g])
      , .load_pc    (loop_pc_i)
      , .load_addr  (loop_addr_i)
      , .load_stride(loop_stride_i)
      , .load_iters (loop_iters_i)
      , .issue      (issue[g])
      , .retire_v   (commit_v_i)
      , .retire_pc  (commit_pc_i)
      , .run        (run[g])
      , .pc         (slot_pc[g])
      , .next_addr  (slot_addr[g])
      , .eligible   (eligible[g])
      );
  end

  // Output buffer: holds its address while stalled, dropped on flush
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      buf_v    <= 1'b0;
      buf_addr <= '0;
      rr_last  <= '0;
    end else if (flush_i) begin
      buf_v <= 1'b0;
    end else if (grant_v) begin
      buf_v    <= 1'b1;
      buf_addr <= slot_addr[grant_idx];
      rr_last  <= grant_idx;
    end else if (pf_ready_i) begin
      buf_v <= 1'b0;
    end
  end

  assign loop_yumi_o = accept;
  assign pf_v_o      = buf_v;
  assign pf_vaddr_o  = buf_addr;
  assign busy_o      = (|run) | buf_v;

endmodule

// File: tb/tb_bp_be_loop_prefetch_scheduler.sv
// Self-checking bench for the loop prefetch scheduler (default parameters).
module tb_bp_be_loop_prefetch_scheduler;

  typedef logic [38:0] va_t;

  typedef struct {
    logic [7:0] iters;
    va_t        addr;
    logic [7:0] stride;
    va_t        exp_first;
    int         exp_cnt;
    logic       exp_busy;
  } vec_t;

  logic       clk;
  logic       reset_i, loop_v_i, loop_yumi_o, commit_v_i, flush_i;
  logic       pf_v_o, pf_ready_i, busy_o;
  logic [7:0] loop_iters_i, loop_stride_i;
  va_t        loop_pc_i, loop_addr_i, commit_pc_i, pf_vaddr_o;

  int errors = 0;
  int checks = 0;

  bp_be_loop_prefetch_scheduler
    #(.output_range_p(8), .stride_width_p(8), .entries_p(2), .lookahead_p(4))
    dut
    (.clk_i        (clk)
    , .reset_i      (reset_i)
    , .loop_v_i     (loop_v_i)
    , .loop_iters_i (loop_iters_i)
    , .loop_pc_i    (loop_pc_i)
    , .loop_addr_i  (loop_addr_i)
    , .loop_stride_i(loop_stride_i)
    , .loop_yumi_o  (loop_yumi_o)
    , .commit_v_i   (commit_v_i)
    , .commit_pc_i  (commit_pc_i)
    , .flush_i      (flush_i)
    , .pf_vaddr_o   (pf_vaddr_o)
    , .pf_v_o       (pf_v_o)
    , .pf_ready_i   (pf_ready_i)
    , .busy_o       (busy_o)
    );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic va_t sx(input logic [7:0] s);
    return {{31{s[7]}}, s};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_i = 1'b1; loop_v_i = 1'b0; commit_v_i = 1'b0; flush_i = 1'b0; pf_ready_i = 1'b1;
    tick(); tick();
    reset_i = 1'b0;
  endtask

  task automatic send(input va_t pc, input va_t addr, input logic [7:0] stride,
                      input logic [7:0] iters, output logic yumi);
    loop_v_i = 1'b1; loop_pc_i = pc; loop_addr_i = addr;
    loop_stride_i = stride; loop_iters_i = iters;
    #1;
    yumi = loop_yumi_o;
    tick();
    loop_v_i = 1'b0;
  endtask

  task automatic run_vectors;
    vec_t vecs[6];
    logic y;
    va_t  e;
    int   cnt;
    vecs[0] = '{8'd3,  39'h1000,         8'd8,   39'h1008,         3, 1'b0};
    vecs[1] = '{8'd10, 39'h1000,         8'd8,   39'h1008,         4, 1'b1};
    vecs[2] = '{8'd1,  39'h0,            8'hFC,  39'h7F_FFFF_FFFC, 1, 1'b0};
    vecs[3] = '{8'd0,  39'h500,          8'd4,   39'h0,            0, 1'b0};
    vecs[4] = '{8'd5,  39'h7F_FFFF_FFFF, 8'd1,   39'h0,            4, 1'b1};
    vecs[5] = '{8'd2,  39'h2000,         8'h80,  39'h1F80,         2, 1'b0};
    for (int v = 0; v < 6; v++) begin
      do_reset();
      send(39'h400, vecs[v].addr, vecs[v].stride, vecs[v].iters, y);
      check($sformatf("vec%0d_yumi", v), y, 1);
      check($sformatf("vec%0d_lat1", v), pf_v_o, 0);
      e = vecs[v].exp_first;
      cnt = 0;
      for (int k = 0; k < 12; k++) begin
        tick();
        if (pf_v_o) cnt++;
        if (k < vecs[v].exp_cnt) begin
          check($sformatf("vec%0d_v%0d", v, k), pf_v_o, 1);
          check($sformatf("vec%0d_addr%0d", v, k), pf_vaddr_o, e);
          e = e + sx(vecs[v].stride);
        end
      end
      check($sformatf("vec%0d_count", v), cnt, vecs[v].exp_cnt);
      check($sformatf("vec%0d_busy", v), busy_o, vecs[v].exp_busy);
    end
  endtask

  task automatic seq_commit;
    logic y;
    int   cnt;
    va_t  last;
    do_reset();
    send(39'h600, 39'h1000, 8'd8, 8'd10, y);
    cnt = 0;
    repeat (10) begin tick(); if (pf_v_o) cnt++; end
    check("la_stall_count", cnt, 4);
    commit_v_i = 1'b1; commit_pc_i = 39'h604;
    tick();
    commit_v_i = 1'b0;
    cnt = 0;
    repeat (6) begin tick(); if (pf_v_o) cnt++; end
    check("la_foreign_commit", cnt, 0);
    commit_v_i = 1'b1; commit_pc_i = 39'h600;
    tick();
    commit_v_i = 1'b0;
    cnt = 0; last = '0;
    repeat (6) begin tick(); if (pf_v_o) begin cnt++; last = pf_vaddr_o; end end
    check("la_one_more_count", cnt, 1);
    check("la_one_more_addr", last, 39'h1028);
  endtask

  task automatic seq_two_streams;
    va_t exp_seq[6];
    logic y;
    bit   got;
    exp_seq[0] = 39'h1008; exp_seq[1] = 39'h2010; exp_seq[2] = 39'h1010;
    exp_seq[3] = 39'h2020; exp_seq[4] = 39'h2030; exp_seq[5] = 39'h2040;
    do_reset();
    send(39'h700, 39'h1000, 8'd8,  8'd2,  y);
    check("rr_yumi_a", y, 1);
    send(39'h800, 39'h2000, 8'd16, 8'd10, y);
    check("rr_yumi_b", y, 1);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("rr_v%0d", k), pf_v_o, 1);
      check($sformatf("rr_addr%0d", k), pf_vaddr_o, exp_seq[k]);
      loop_v_i = (k < 2); loop_pc_i = 39'h900; loop_addr_i = 39'h4000;
      loop_stride_i = 8'd4; loop_iters_i = 8'd1;
      #1;
      if (k < 2) check($sformatf("rr_full_yumi%0d", k), loop_yumi_o, 0);
      tick();
    end
    loop_v_i = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      #1;
      if (loop_yumi_o) got = 1'b1;
      tick();
    end
    loop_v_i = 1'b0;
    check("rr_third_accept", got, 1);
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      if (pf_v_o && pf_vaddr_o == 39'h4004) got = 1'b1;
      tick();
    end
    check("rr_third_pf", got, 1);
  endtask

  task automatic seq_stall_flush;
    logic y;
    do_reset();
    pf_ready_i = 1'b0;
    send(39'hA00, 39'h5000, 8'd8, 8'd10, y);
    tick();
    check("stall_v", pf_v_o, 1);
    check("stall_addr", pf_vaddr_o, 39'h5008);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("stall_hold%0d", k), {pf_v_o, pf_vaddr_o}, {1'b1, 39'h5008});
    end
    flush_i = 1'b1; pf_ready_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_pf_v", pf_v_o, 0);
    check("flush_busy", busy_o, 0);
    tick();
    check("flush_quiet", pf_v_o, 0);
  endtask

  task automatic seq_refresh;
    logic y;
    va_t  exp_seq[4];
    exp_seq[0] = 39'h3008; exp_seq[1] = 39'h3010; exp_seq[2] = 39'h3018; exp_seq[3] = 39'h3020;
    do_reset();
    send(39'hB00, 39'h1000, 8'd8, 8'd10, y);
    tick();
    check("ref_first", pf_vaddr_o, 39'h1008);
    send(39'hB00, 39'h3000, 8'd8, 8'd10, y);
    check("ref_yumi", y, 1);
    check("ref_old_issue", {pf_v_o, pf_vaddr_o}, {1'b1, 39'h1010});
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("ref_new%0d", k), {pf_v_o, pf_vaddr_o}, {1'b1, exp_seq[k]});
    end
    tick();
    check("ref_stall", pf_v_o, 0);
  endtask

  task automatic rand_round(input int r);
    va_t        qa[$], qb[$];
    va_t        ba, bb, e, prev_addr, exp;
    logic [7:0] sa, sb;
    int         na, nb, oa, ob, sel;
    logic       y, prev_stall;
    do_reset();
    sa = 8'($urandom_range(1, 127));
    sb = 8'($urandom_range(128, 255));
    na = $urandom_range(1, 30);
    nb = $urandom_range(1, 30);
    ba = 39'h10000 + va_t'($urandom_range(0, 255)) * 16;
    bb = 39'h4000000;
    e = ba; for (int k = 0; k < na; k++) begin e = e + sx(sa); qa.push_back(e); end
    e = bb; for (int k = 0; k < nb; k++) begin e = e + sx(sb); qb.push_back(e); end
    send(39'hC00, ba, sa, 8'(na), y);
    check($sformatf("rand%0d_yumi_a", r), y, 1);
    send(39'hD00, bb, sb, 8'(nb), y);
    check($sformatf("rand%0d_yumi_b", r), y, 1);
    oa = 0; ob = 0; prev_stall = 1'b0; prev_addr = '0;
    for (int cyc = 0; cyc < 3000 && (qa.size() + qb.size()) > 0; cyc++) begin
      if (prev_stall) check($sformatf("rand%0d_hold", r), {pf_v_o, pf_vaddr_o}, {1'b1, prev_addr});
      pf_ready_i = ($urandom_range(0, 2) != 0);
      sel = $urandom_range(0, 3);
      commit_v_i = 1'b0;
      if (sel == 0 && oa > 0) begin commit_v_i = 1'b1; commit_pc_i = 39'hC00; oa--; end
      else if (sel == 1 && ob > 0) begin commit_v_i = 1'b1; commit_pc_i = 39'hD00; ob--; end
      #1;
      prev_stall = pf_v_o & ~pf_ready_i;
      prev_addr  = pf_vaddr_o;
      if (pf_v_o && pf_ready_i) begin
        if (qa.size() > 0 && pf_vaddr_o == qa[0]) begin
          exp = qa.pop_front(); oa++;
          check($sformatf("rand%0d_lookahead_a", r), oa <= 4, 1);
        end else if (qb.size() > 0 && pf_vaddr_o == qb[0]) begin
          exp = qb.pop_front(); ob++;
          check($sformatf("rand%0d_lookahead_b", r), ob <= 4, 1);
        end else begin
          exp = (qa.size() > 0) ? qa[0] : ((qb.size() > 0) ? qb[0] : '0);
        end
        check($sformatf("rand%0d_addr", r), pf_vaddr_o, exp);
      end
      tick();
    end
    commit_v_i = 1'b0; pf_ready_i = 1'b1;
    check($sformatf("rand%0d_drain", r), qa.size() + qb.size(), 0);
    repeat (4) tick();
    check($sformatf("rand%0d_idle", r), busy_o, 0);
  endtask

  initial begin
    reset_i = 1'b1; loop_v_i = 1'b1; loop_iters_i = 8'd3; loop_pc_i = 39'h100;
    loop_addr_i = 39'h1000; loop_stride_i = 8'd8; commit_v_i = 1'b0; commit_pc_i = '0;
    flush_i = 1'b0; pf_ready_i = 1'b1;
    tick(); tick();
    check("reset_yumi", loop_yumi_o, 0);
    check("reset_pf_v", pf_v_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_vaddr", pf_vaddr_o, 0);
    loop_v_i = 1'b0; reset_i = 1'b0;
    tick();

    run_vectors();
    seq_commit();
    seq_two_streams();
    seq_stall_flush();
    seq_refresh();
    for (int r = 0; r < 3; r++) rand_round(r);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
